// File: rtl/radix4_online_ctrl.sv
// Sequencer for one radix-4 online (MSD-first) operation: INIT for delta
// iterations, RUN digit-in/digit-out, FLUSH with zero operands, then DONE.
module radix4_online_ctrl #(
  parameter int no_of_digits = 4,
  parameter int radix_bits   = 3,
  parameter int delta        = 2,
  localparam int CW          = $clog2(no_of_digits + delta + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          digit_load,
  output logic          zero_in,
  output logic          res_en,
  output logic          clr_w,
  output logic          sel_reset,
  output logic [CW-1:0] iter_idx,
  output logic          last_digit,
  output logic          busy,
  output logic          done
);

  if (no_of_digits <= delta || radix_bits < 2) begin : g_bad_params
    $error("radix4_online_ctrl: need no_of_digits > delta and radix_bits >= 2");
  end

  localparam logic [CW-1:0] InitLast  = CW'(delta - 1);
  localparam logic [CW-1:0] RunLast   = CW'(no_of_digits - 1);
  localparam logic [CW-1:0] FlushLast = CW'(no_of_digits + delta - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] iter_q, iter_d;
  logic          step;

  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    step       = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    zero_in    = 1'b0;
    clr_w      = 1'b0;
    sel_reset  = 1'b1;
    last_digit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          clr_w   = 1'b1;
          state_d = S_INIT;
          iter_d  = '0;
        end
      end
      S_INIT: begin
        in_ready = 1'b1;
        step     = in_valid;
        if (step) begin
          iter_d = iter_q + CW'(1);
          if (iter_q == InitLast) state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Both streams advance together so no digit is dropped or repeated.
        sel_reset = 1'b0;
        out_valid = in_valid;
        in_ready  = out_ready;
        step      = in_valid & out_ready;
        if (step) begin
          iter_d = iter_q + CW'(1);
          if (iter_q == RunLast) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        sel_reset  = 1'b0;
        zero_in    = 1'b1;
        out_valid  = 1'b1;
        step       = out_ready;
        last_digit = (iter_q == FlushLast);
        if (step) begin
          if (last_digit) begin
            state_d = S_DONE;
            iter_d  = '0;
          end else begin
            iter_d = iter_q + CW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        iter_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        iter_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  assign res_en     = step;
  assign digit_load = in_valid & in_ready;
  assign iter_idx   = iter_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_radix4_online_ctrl.sv
// Directed bench for radix4_online_ctrl: default (4,2) instance plus an (8,3) one.
module tb_radix4_online_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, in_valid, out_ready;
  logic in_ready, out_valid, digit_load, zero_in, res_en, clr_w, sel_reset;
  logic last_digit, busy, done;
  logic [2:0] iter_idx;

  logic b_start, b_in_valid, b_out_ready;
  logic b_in_ready, b_out_valid, b_digit_load, b_zero_in, b_res_en, b_clr_w, b_sel_reset;
  logic b_last_digit, b_busy, b_done;
  logic [3:0] b_iter_idx;

  radix4_online_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .digit_load(digit_load), .zero_in(zero_in),
    .res_en(res_en), .clr_w(clr_w), .sel_reset(sel_reset), .iter_idx(iter_idx),
    .last_digit(last_digit), .busy(busy), .done(done)
  );

  radix4_online_ctrl #(.no_of_digits(8), .radix_bits(3), .delta(3)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .digit_load(b_digit_load),
    .zero_in(b_zero_in), .res_en(b_res_en), .clr_w(b_clr_w), .sel_reset(b_sel_reset),
    .iter_idx(b_iter_idx), .last_digit(b_last_digit), .busy(b_busy), .done(b_done)
  );

  // {busy,clr_w,in_ready,out_valid,digit_load,zero_in,res_en,sel_reset,last_digit,done}
  wire [9:0] obs   = {busy, clr_w, in_ready, out_valid, digit_load, zero_in, res_en,
                      sel_reset, last_digit, done};
  wire [9:0] b_obs = {b_busy, b_clr_w, b_in_ready, b_out_valid, b_digit_load, b_zero_in,
                      b_res_en, b_sel_reset, b_last_digit, b_done};

  localparam logic [9:0] R_IDLE  = 10'b0000000100;
  localparam logic [9:0] R_START = 10'b0100000100;
  localparam logic [9:0] R_INIT  = 10'b1010101100;
  localparam logic [9:0] R_RUN   = 10'b1011101000;
  localparam logic [9:0] R_FL    = 10'b1001011000;
  localparam logic [9:0] R_FLL   = 10'b1001011010;
  localparam logic [9:0] R_DONE  = 10'b1000000001;
  localparam logic [9:0] M_ALL   = 10'b1111111111;
  localparam logic [9:0] M_DONE  = 10'b1111111011;

  int total = 0;
  int bad   = 0;
  int in_acc, out_acc;

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    b_start = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    next_cycle(); next_cycle();
    @(negedge clk);
    total++;
    if (obs !== R_IDLE || iter_idx !== 3'd0) begin
      bad++; $display("FAIL reset_a: got %b/%0d want %b/0", obs, iter_idx, R_IDLE);
    end
    total++;
    if (b_obs !== R_IDLE || b_iter_idx !== 4'd0) begin
      bad++; $display("FAIL reset_b: got %b/%0d want %b/0", b_obs, b_iter_idx, R_IDLE);
    end
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_basic;
    logic [9:0] rows [0:8] = '{R_START, R_INIT, R_INIT, R_RUN, R_RUN, R_FL, R_FLL, R_DONE, R_IDLE};
    int         its  [0:8] = '{0, 0, 1, 2, 3, 4, 5, 0, 0};
    in_acc = 0; out_acc = 0;
    for (int c = 0; c < 9; c++) begin
      start = (c == 0); in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_acc += int'(digit_load); out_acc += int'(out_valid & out_ready);
      total++;
      if ((obs & (c == 7 ? M_DONE : M_ALL)) !== (rows[c] & (c == 7 ? M_DONE : M_ALL)) ||
          (c != 7 && int'(iter_idx) != its[c])) begin
        bad++; $display("FAIL basic_c%0d: got %b/%0d want %b/%0d", c, obs, iter_idx, rows[c], its[c]);
      end
      next_cycle();
    end
    start = 1'b0;
    total++;
    if (in_acc != 4 || out_acc != 4) begin
      bad++; $display("FAIL basic_counts: got %0d/%0d want 4/4", in_acc, out_acc);
    end
  endtask

  task automatic test_in_stall;
    logic [9:0] rows [0:10] = '{R_START, R_INIT, 10'b1010000100, R_INIT, 10'b1010000000,
                                R_RUN, R_RUN, R_FL, R_FLL, R_DONE, R_IDLE};
    int         its  [0:10] = '{0, 0, 1, 1, 2, 2, 3, 4, 5, 0, 0};
    in_acc = 0; out_acc = 0;
    for (int c = 0; c < 11; c++) begin
      start = (c == 0); in_valid = !(c == 2 || c == 4); out_ready = 1'b1;
      @(negedge clk);
      in_acc += int'(digit_load); out_acc += int'(out_valid & out_ready);
      total++;
      if ((obs & (c == 9 ? M_DONE : M_ALL)) !== (rows[c] & (c == 9 ? M_DONE : M_ALL)) ||
          (c != 9 && int'(iter_idx) != its[c])) begin
        bad++; $display("FAIL in_stall_c%0d: got %b/%0d want %b/%0d", c, obs, iter_idx, rows[c], its[c]);
      end
      next_cycle();
    end
    start = 1'b0;
    total++;
    if (in_acc != 4 || out_acc != 4) begin
      bad++; $display("FAIL in_stall_counts: got %0d/%0d want 4/4", in_acc, out_acc);
    end
  endtask

  task automatic test_flush_stall;
    logic [9:0] rows [0:11] = '{R_START, R_INIT, R_INIT, R_RUN, R_RUN, 10'b1001010000,
                                10'b1001010000, 10'b1001010000, R_FL, R_FLL, R_DONE, R_IDLE};
    int         its  [0:11] = '{0, 0, 1, 2, 3, 4, 4, 4, 4, 5, 0, 0};
    in_acc = 0; out_acc = 0;
    for (int c = 0; c < 12; c++) begin
      start = (c == 0); in_valid = 1'b1; out_ready = !(c >= 5 && c <= 7);
      @(negedge clk);
      in_acc += int'(digit_load); out_acc += int'(out_valid & out_ready);
      total++;
      if ((obs & (c == 10 ? M_DONE : M_ALL)) !== (rows[c] & (c == 10 ? M_DONE : M_ALL)) ||
          (c != 10 && int'(iter_idx) != its[c])) begin
        bad++; $display("FAIL flush_stall_c%0d: got %b/%0d want %b/%0d", c, obs, iter_idx, rows[c], its[c]);
      end
      next_cycle();
    end
    start = 1'b0; out_ready = 1'b1;
    total++;
    if (in_acc != 4 || out_acc != 4) begin
      bad++; $display("FAIL flush_stall_counts: got %0d/%0d want 4/4", in_acc, out_acc);
    end
  endtask

  task automatic test_reset_mid_run;
    for (int c = 0; c < 5; c++) begin
      start = (c == 0); in_valid = 1'b1; out_ready = 1'b1; reset = (c == 4);
      @(negedge clk);
      if (c == 4) begin
        total++;
        if (obs !== R_RUN || iter_idx !== 3'd3) begin
          bad++; $display("FAIL rst_pre: got %b/%0d want %b/3", obs, iter_idx, R_RUN);
        end
      end
      next_cycle();
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== R_IDLE || iter_idx !== 3'd0) begin
      bad++; $display("FAIL rst_post: got %b/%0d want %b/0", obs, iter_idx, R_IDLE);
    end
    next_cycle();
    test_basic();
  endtask

  task automatic test_start_held;
    logic [9:0] rows [0:9] = '{R_START, R_INIT, R_INIT, R_RUN, R_RUN, R_FL, R_FLL, R_DONE,
                               R_START, R_INIT};
    int         its  [0:9] = '{0, 0, 1, 2, 3, 4, 5, 0, 0, 0};
    int done_at = -1;
    for (int c = 0; c < 10; c++) begin
      start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      total++;
      if ((obs & (c == 7 ? M_DONE : M_ALL)) !== (rows[c] & (c == 7 ? M_DONE : M_ALL)) ||
          (c != 7 && int'(iter_idx) != its[c])) begin
        bad++; $display("FAIL start_held_c%0d: got %b/%0d want %b/%0d", c, obs, iter_idx, rows[c], its[c]);
      end
      next_cycle();
    end
    start = 1'b0;
    for (int c = 10; c < 20; c++) begin
      @(negedge clk);
      if (done && done_at < 0) done_at = c;
      next_cycle();
    end
    total++;
    if (done_at != 15) begin
      bad++; $display("FAIL start_held_done: got cycle %0d want 15", done_at);
    end
    @(negedge clk);
    total++;
    if (obs !== R_IDLE) begin
      bad++; $display("FAIL start_held_idle: got %b want %b", obs, R_IDLE);
    end
    next_cycle();
  endtask

  task automatic test_long_params;
    logic [9:0] want;
    int wit;
    in_acc = 0; out_acc = 0;
    for (int c = 0; c < 14; c++) begin
      b_start = (c == 0); b_in_valid = 1'b1; b_out_ready = 1'b1;
      if (c == 0)       begin want = R_START; wit = 0; end
      else if (c <= 3)  begin want = R_INIT;  wit = c - 1; end
      else if (c <= 8)  begin want = R_RUN;   wit = c - 1; end
      else if (c <= 10) begin want = R_FL;    wit = c - 1; end
      else if (c == 11) begin want = R_FLL;   wit = 10; end
      else if (c == 12) begin want = R_DONE;  wit = 0; end
      else              begin want = R_IDLE;  wit = 0; end
      @(negedge clk);
      in_acc += int'(b_digit_load); out_acc += int'(b_out_valid & b_out_ready);
      total++;
      if ((b_obs & (c == 12 ? M_DONE : M_ALL)) !== (want & (c == 12 ? M_DONE : M_ALL)) ||
          (c != 12 && int'(b_iter_idx) != wit)) begin
        bad++; $display("FAIL long_c%0d: got %b/%0d want %b/%0d", c, b_obs, b_iter_idx, want, wit);
      end
      next_cycle();
    end
    b_start = 1'b0;
    total++;
    if (in_acc != 8 || out_acc != 8) begin
      bad++; $display("FAIL long_counts: got %0d/%0d want 8/8", in_acc, out_acc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_in_stall();
    test_flush_stall();
    test_reset_mid_run();
    test_start_held();
    test_long_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/radix4_online_ctrl.md
Name: radix4_online_ctrl

Overview:
Sequencing controller for one radix-4 online (digit-serial, MSD-first) operation built around the radix-4 digit-selection function and residual datapath. It walks one operation through initialization (delta iterations, no output), steady-state (consume one operand digit pair and emit one result digit per iteration), and flush (zero operand digits and emit the remaining result digits). It also drives the selection-function reset, the residual clear, and the valid/ready handshakes on the digit streams.

Parameters:
no_of_digits, 4, operand/result length in radix-4 digits; must be greater than delta
radix_bits, 3, width of one signed digit; carried for interface consistency, no logic depends on it
delta, 2, online delay in iterations
CW, $clog2(no_of_digits+delta+1), iteration counter width (derived, localparam)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high; returns block to IDLE
start  input  1  request a new operation; sampled only in IDLE
in_valid  input  1  operand digit pair (x_j, y_j) present
in_ready  output  1  controller accepts operand digit pair this cycle
out_valid  output  1  result digit p_j from selection function is valid
out_ready  input  1  downstream accepts result digit
digit_load  output  1  load enable for operand digit registers (= in_valid & in_ready)
zero_in  output  1  datapath substitutes 0 for operand digits (flush)
res_en  output  1  residual register update enable (one per iteration step)
clr_w  output  1  clear residual register and operand shift registers
sel_reset  output  1  drives selection-function reset (forces p_j=0)
iter_idx  output  CW  current iteration, 0 .. no_of_digits+delta-1
last_digit  output  1  qualifies the final result digit
busy  output  1  operation in progress (state not IDLE)
done  output  1  one-cycle pulse after the final result digit is accepted

Behaviour:
- States: IDLE, INIT, RUN, FLUSH, DONE. Registered state and iter_idx; handshake outputs are combinational from state and inputs.
- Reset values: state=IDLE, iter_idx=0, busy=0, done=0, in_ready=0, out_valid=0, digit_load=0, zero_in=0, res_en=0, clr_w=0, last_digit=0, sel_reset=1.
- IDLE: sel_reset=1. If start=1: clr_w=1 that cycle, next state INIT, iter_idx=0.
- INIT (iter_idx 0..delta-1): in_ready=1, out_valid=0, sel_reset=1. step=in_valid. On step: res_en=1, iter_idx++. Step at iter_idx=delta-1 goes to RUN.
- RUN (iter_idx delta..no_of_digits-1): out_valid=in_valid, in_ready=out_ready, sel_reset=0. step=in_valid & out_ready. Neither side advances alone; no digit is lost or duplicated. Step at iter_idx=no_of_digits-1 goes to FLUSH.
- FLUSH (iter_idx no_of_digits..no_of_digits+delta-1): in_ready=0, zero_in=1, out_valid=1, sel_reset=0. step=out_ready. last_digit=1 at iter_idx=no_of_digits+delta-1. Step there goes to DONE.
- res_en=step in INIT, RUN and FLUSH. digit_load=in_valid & in_ready.
- DONE: done=1, busy=1, all handshakes 0. Unconditionally goes to IDLE next cycle.
- busy=1 in every state except IDLE. start outside IDLE is ignored, with no effect on the counter or state.
- Totals per operation: exactly no_of_digits input accepts and no_of_digits output accepts. Minimum latency is start-to-done = no_of_digits+delta+1 cycles after the start cycle.
- Reset asserted in any state: next cycle all outputs equal their reset values; the partial operation is discarded.
- A long stall in any state holds state, iter_idx and all outputs stable.

Test Plan:
1. Defaults, in_valid=out_ready=1, start at cycle 0 -> clr_w@0; INIT cycles 1-2; RUN 3-4 (out_valid=1, sel_reset=0); FLUSH 5-6 (zero_in=1, last_digit@6); done@7; IDLE@8. Counts: 4 input accepts, 4 output accepts.
2. in_valid low at cycles 2 and 4 -> iter_idx holds during those cycles; out_valid=0 at cycle 4; done is delayed by 2 cycles; accept counts are still 4/4.
3. out_ready=0 during the whole FLUSH for 3 cycles -> out_valid stays 1, iter_idx frozen at 4, last_digit not asserted until iter_idx=5; done follows the last accept.
4. Reset pulse during RUN at iter_idx=3 -> next cycle state IDLE, busy=0, sel_reset=1, iter_idx=0. A fresh start completes normally.
5. start held high through the whole operation -> no restart while busy. A new operation begins only from IDLE (cycle 8 in scenario 1), with clr_w at that cycle.
6. no_of_digits=8, delta=3, always ready -> INIT is 3 iterations, RUN is 5, FLUSH is 3; done at cycle 12.
